eeg_window_gen: RTL and testbench
=================================

// Module: eeg_window_gen
// PURPOSE
//  Multi-channel sliding-window generator with configurable hop (stride) and valid/ready handshake.
//  Sits between the EEG sample front-end and the ATCNet conv input stage.
//  Accepts one time step (all channels) per beat; emits a registered snapshot of the last
//  WINDOW_SIZE time steps every STRIDE accepted steps once the buffer is full.
// PARAMETERS
//  DATA_W      16  bits per sample
//  NUM_CH      22  channels per time step
//  WINDOW_SIZE 32  time steps per window (>=2)
//  STRIDE       8  accepted time steps between successive windows (1..WINDOW_SIZE)
//  IDX_W       16  width of window sequence index
// PORTS
//  clk          in   1                          clock
//  rst          in   1                          synchronous, active-high reset
//  flush        in   1                          restart fill; buffer contents become don't-care
//  in_valid     in   1                          input time step valid
//  in_ready     out  1                          block can accept time step
//  in_sample    in   NUM_CH*DATA_W              ch c at [c*DATA_W +: DATA_W]
//  out_valid    out  1                          window snapshot valid
//  out_ready    in   1                          downstream accepts window
//  out_window   out  NUM_CH*WINDOW_SIZE*DATA_W  ch c, time t (0=oldest) at [(c*WINDOW_SIZE+t)*DATA_W +: DATA_W]
//  out_win_idx  out  IDX_W                      sequence number of window generated (wraps)
//  drop_cnt     out  16                         windows dropped (drop mode only, else 0)
// BEHAVIOUR
//  - Reset: out_valid=0, out_window=0, out_win_idx=0, drop_cnt=0, fill_cnt=0, hop_cnt=0, wr_ptr=0.
//  - Accept: in_valid && in_ready. All channels written to ring at wr_ptr; wr_ptr wraps WINDOW_SIZE-1 -> 0.
//  - fill_cnt counts accepted steps, saturates at WINDOW_SIZE. hop_cnt counts 0..STRIDE-1 once full.
//  - Window event (accept-cycle): first when accept makes fill_cnt reach WINDOW_SIZE; thereafter when
//    full and hop_cnt==STRIDE-1 on accept. hop_cnt clears to 0 on every event.
//  - Latency 1: cycle after event, out_valid=1, out_window = last WINDOW_SIZE steps incl. the event
//    sample, oldest at t=0; out_win_idx = events generated before this one (first window = 0).
//  - Output hold: out_window/out_win_idx stable while out_valid && !out_ready. out_valid clears
//    on out_ready unless a new event loads the register the same cycle (back-to-back allowed, STRIDE=1).
//  - Stall mode (default): in_ready = !(out_valid && !out_ready && next_accept_is_event).
//    Combinational from out_ready; no sample is lost, no window dropped.
//  - flush: fill_cnt, hop_cnt, wr_ptr -> 0 next cycle; a sample presented with flush is discarded;
//    pending out_valid/out_window untouched; out_win_idx continues.
//  - flush and rst same cycle: rst wins. rst mid-transfer drops pending window.
//  - Widths: hop_cnt $clog2(STRIDE) (min 1 bit), fill_cnt $clog2(WINDOW_SIZE+1); drop_cnt saturates at 16'hFFFF.
// CONFIGURATION
//  EEG_WINDOW_DROP_MODE_EN defined: in_ready tied 1; event while out_valid && !out_ready ->
//    window dropped, output register unchanged, drop_cnt++ (saturating), out_win_idx still
//    advances so consumers see gaps.
//  Undefined: stall mode as above; drop_cnt tied 0.
// STRUCTURE
//  Package eeg_window_pkg: DATA_W/NUM_CH/WINDOW_SIZE/STRIDE defaults, sample_t (logic [DATA_W-1:0]),
//    frame_t (sample_t [NUM_CH-1:0]), IDX_W, DROP_CNT_W=16.
//  Sub-module eeg_window_ring: circular storage, NUM_CH x WINDOW_SIZE, write port + combinational
//    oldest->newest unrolled read (index = wr_ptr+t, wrap by subtract, no modulo).
//  Top: fill/hop counters, event logic, handshake, output register, drop counter.
// TESTING (NUM_CH=2, WINDOW_SIZE=4, STRIDE=2, DATA_W=16; sample k = {ch1=16'h100+k, ch0=k})
//  1 Fill: stream k=0..3, out_ready=1 -> one out_valid 1 cycle after k=3, ch0 t0..3 = 0,1,2,3, idx=0; none earlier.
//  2 Stride: continue k=4..7 -> windows after k=5 (ch0 2..5, idx=1) and k=7 (ch0 4..7, idx=2); ch1 = 0x102..0x105 for idx=1.
//  3 Backpressure (stall): out_ready=0 after idx=1 -> in_ready drops when k=7 offered; hold 5 cycles;
//    window stable; release -> idx=2 = ch0 4..7, no sample lost.
//  4 Drop mode (EEG_WINDOW_DROP_MODE_EN): same as 3 -> in_ready stays 1, drop_cnt=1 after k=7,
//    next delivered window idx=3 (ch0 6..9).
//  5 Flush: after k=5 assert flush with k=6 -> k=6 discarded; next window only after 4 new samples
//    (k=7..10), contents 7..10, idx continues.
//  6 STRIDE=1 + out_ready=1 continuous: out_valid stays high; a new window every cycle, idx increments by 1; rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/eeg_window_pkg.sv
// eeg_window_pkg: shared defaults and types for the EEG sliding-window generator.
// Ports: none (package). Build option: EEG_WINDOW_DROP_MODE_EN selects drop mode in eeg_window_gen.
// Contents: default geometry, sample/frame types, drop counter width, clog2 helper.
package eeg_window_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_NUM_CH      = 22;
    localparam int DEF_WINDOW_SIZE = 32;
    localparam int DEF_STRIDE      = 8;
    localparam int DEF_IDX_W       = 16;
    localparam int DROP_CNT_W      = 16;

    typedef logic [DEF_DATA_W-1:0]   sample_t;
    typedef sample_t [DEF_NUM_CH-1:0] frame_t;

    // Counter widths must never collapse to zero bits when a dimension is 1.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/eeg_window_ring.sv
// eeg_window_ring: circular store of WINDOW_SIZE time-step frames (NUM_CH samples each).
// Latency: write lands on the next clk edge; read is combinational from storage.
// Ports: clk, i_wr_en/i_ptr/i_wr_dat write port; o_rd_dat frame t = mem[(i_ptr+t) wrapped].
module eeg_window_ring
    import eeg_window_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
    parameter int PTR_W       = clog2_min1(DEF_WINDOW_SIZE)
)(
    input  logic                                  clk,
    input  logic                                  i_wr_en,
    input  logic [PTR_W-1:0]                      i_ptr,
    input  logic [NUM_CH*DATA_W-1:0]              i_wr_dat,
    output logic [WINDOW_SIZE*NUM_CH*DATA_W-1:0]  o_rd_dat
);

    localparam int FRAME_W = NUM_CH * DATA_W;

    // Storage has no reset: contents are don't-care until refilled.
    logic [FRAME_W-1:0] r_mem [WINDOW_SIZE];
    logic [PTR_W:0]     w_idx;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_ptr] <= i_wr_dat;
        end
    end

    // Unrolled read starting at the pointer. Pointer plus offset stays below
    // 2*WINDOW_SIZE, so one conditional subtract wraps it without a modulo.
    always_comb begin
        o_rd_dat = '0;
        w_idx    = '0;
        for (int t = 0; t < WINDOW_SIZE; t++) begin
            w_idx = {1'b0, i_ptr} + (PTR_W+1)'(t);
            if (w_idx >= (PTR_W+1)'(WINDOW_SIZE)) begin
                w_idx = w_idx - (PTR_W+1)'(WINDOW_SIZE);
            end
            o_rd_dat[t*FRAME_W +: FRAME_W] = r_mem[w_idx[PTR_W-1:0]];
        end
    end

endmodule

// File: rtl/eeg_window_gen.sv
// eeg_window_gen: multi-channel sliding-window generator between the EEG front-end and the conv input.
// Latency 1 from the accept that completes a window to out_valid. Stall mode (default) deasserts
// in_ready only when the next accept would produce a window that cannot be loaded; build with
// EEG_WINDOW_DROP_MODE_EN to keep in_ready high and drop such windows (counted in drop_cnt).
// Ports: clk, rst (sync, active-high), flush, in_valid/in_ready/in_sample (one time step),
//        out_valid/out_ready/out_window (ch c, time t at [(c*WINDOW_SIZE+t)*DATA_W]), out_win_idx, drop_cnt.
module eeg_window_gen
    import eeg_window_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
    parameter int STRIDE      = DEF_STRIDE,
    parameter int IDX_W       = DEF_IDX_W
)(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_CH*DATA_W-1:0]             in_sample,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_CH*WINDOW_SIZE*DATA_W-1:0] out_window,
    output logic [IDX_W-1:0]                     out_win_idx,
    output logic [DROP_CNT_W-1:0]                drop_cnt
);

    localparam int FRAME_W = NUM_CH * DATA_W;
    localparam int WIN_W   = NUM_CH * WINDOW_SIZE * DATA_W;
    localparam int PTR_W   = clog2_min1(WINDOW_SIZE);
    localparam int HOP_W   = clog2_min1(STRIDE);
    localparam int FILL_W  = $clog2(WINDOW_SIZE + 1);

    logic [FILL_W-1:0]  r_fill_cnt;
    logic [HOP_W-1:0]   r_hop_cnt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [IDX_W-1:0]   r_evt_cnt;
    logic               r_out_valid;
    logic [WIN_W-1:0]   r_out_window;
    logic [IDX_W-1:0]   r_out_win_idx;

    logic               w_full;
    logic               w_next_is_event;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_event;
    logic               w_load;
    logic [WINDOW_SIZE*FRAME_W-1:0] w_rd;
    logic [WIN_W-1:0]   w_win_nxt;

    assign w_full = (r_fill_cnt == FILL_W'(WINDOW_SIZE));

    // Would an accept this cycle complete a window? Either the fill finishes
    // now, or the buffer is full and the hop counter has reached its last step.
    assign w_next_is_event = w_full ? (r_hop_cnt == HOP_W'(STRIDE - 1))
                                    : (r_fill_cnt == FILL_W'(WINDOW_SIZE - 1));

    // A sample offered together with flush is discarded, never written.
    assign w_accept = in_valid && w_in_ready && !flush;
    assign w_event  = w_accept && w_next_is_event;

    // The output register takes a new window only if it is empty or being drained.
    assign w_load   = w_event && (!r_out_valid || out_ready);

    eeg_window_ring #(
        .DATA_W      (DATA_W),
        .NUM_CH      (NUM_CH),
        .WINDOW_SIZE (WINDOW_SIZE),
        .PTR_W       (PTR_W)
    ) u_ring (
        .clk      (clk),
        .i_wr_en  (w_accept),
        .i_ptr    (r_wr_ptr),
        .i_wr_dat (in_sample),
        .o_rd_dat (w_rd)
    );

    // Ring frame 0 sits at wr_ptr and is the one being overwritten by the event
    // sample, so the snapshot is ring frames 1..WINDOW_SIZE-1 followed by the
    // incoming sample as the newest time step.
    always_comb begin
        w_win_nxt = '0;
        for (int t = 0; t < WINDOW_SIZE; t++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (t == WINDOW_SIZE - 1) begin
                    w_win_nxt[(c*WINDOW_SIZE+t)*DATA_W +: DATA_W] = in_sample[c*DATA_W +: DATA_W];
                end else begin
                    w_win_nxt[(c*WINDOW_SIZE+t)*DATA_W +: DATA_W] = w_rd[((t+1)*NUM_CH+c)*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Fill / hop / write-pointer bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_fill_cnt <= '0;
            r_hop_cnt  <= '0;
            r_wr_ptr   <= '0;
        end else if (w_accept) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(WINDOW_SIZE - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (!w_full) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end
            if (w_event) begin
                r_hop_cnt <= '0;
            end else if (w_full) begin
                r_hop_cnt <= r_hop_cnt + 1'b1;
            end
        end
    end

    // Window sequence number counts every generated window, including dropped
    // ones, and survives flush so consumers can spot gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt_cnt <= '0;
        end else if (w_event) begin
            r_evt_cnt <= r_evt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_window  <= '0;
            r_out_win_idx <= '0;
        end else if (w_load) begin
            r_out_valid   <= 1'b1;
            r_out_window  <= w_win_nxt;
            r_out_win_idx <= r_evt_cnt;
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

`ifdef EEG_WINDOW_DROP_MODE_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    // A window that finds the output register still occupied is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_event && r_out_valid && !out_ready && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign w_in_ready = 1'b1;
    assign drop_cnt   = r_drop_cnt;
`else
    // Stall only the accept that would create a window with nowhere to go.
    assign w_in_ready = !(r_out_valid && !out_ready && w_next_is_event);
    assign drop_cnt   = '0;
`endif

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_window  = r_out_window;
    assign out_win_idx = r_out_win_idx;

endmodule

// File: tb/tb_eeg_window_gen.sv
// tb_eeg_window_gen: directed bench for eeg_window_gen (NUM_CH=2, WINDOW_SIZE=4, DATA_W=16).
// Instance dut uses STRIDE=2; instance dut1 uses STRIDE=1 for the continuous-stream case.
// Sample k = {ch1 = 16'h100+k, ch0 = k}.
module tb_eeg_window_gen;

    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int WS  = 4;
    localparam int IW  = 16;
    localparam int WW  = NCH * WS * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;

    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NCH*DW-1:0] in_sample = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [WW-1:0] out_window;
    logic [IW-1:0] out_win_idx;
    logic [15:0]   drop_cnt;

    logic          flush1 = 1'b0;
    logic          in_valid1 = 1'b0;
    logic          in_ready1;
    logic [NCH*DW-1:0] in_sample1 = '0;
    logic          out_valid1;
    logic          out_ready1 = 1'b1;
    logic [WW-1:0] out_window1;
    logic [IW-1:0] out_win_idx1;
    logic [15:0]   drop_cnt1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    eeg_window_gen #(.DATA_W(DW), .NUM_CH(NCH), .WINDOW_SIZE(WS), .STRIDE(2), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
        .out_win_idx(out_win_idx), .drop_cnt(drop_cnt)
    );

    eeg_window_gen #(.DATA_W(DW), .NUM_CH(NCH), .WINDOW_SIZE(WS), .STRIDE(1), .IDX_W(IW)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_sample(in_sample1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_window(out_window1),
        .out_win_idx(out_win_idx1), .drop_cnt(drop_cnt1)
    );

    function automatic logic [DW-1:0] wsel(input logic [WW-1:0] w, input int c, input int t);
        return w[(c*WS+t)*DW +: DW];
    endfunction

    function automatic logic [NCH*DW-1:0] smp(input int k);
        logic [15:0] kk;
        kk = 16'(k);
        return {16'h0100 + kk, kk};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer sample k until accepted (bounded); returns just after the accepting edge.
    task automatic send(input int k);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = smp(k);
        n = 0;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout k=%0d: in_ready stayed 0, required 1", k);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_cmp++; if (out_window !== '0) begin n_fail++; $display("FAIL reset_window got %h exp 0", out_window); end
        n_cmp++; if (out_win_idx !== '0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", out_win_idx); end
        n_cmp++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_fill_and_stride();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send(k);
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_early k=%0d got %b exp 0", k, out_valid); end
        end
        send(3);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid got %b exp 1", out_valid); end
        n_cmp++; if (out_win_idx !== 16'd0) begin n_fail++; $display("FAIL fill_idx got %0d exp 0", out_win_idx); end
        for (int t = 0; t < WS; t++) begin
            n_cmp++; if (wsel(out_window, 0, t) !== 16'(t)) begin n_fail++; $display("FAIL fill_ch0 t=%0d got %h exp %h", t, wsel(out_window, 0, t), 16'(t)); end
            n_cmp++; if (wsel(out_window, 1, t) !== 16'h100 + 16'(t)) begin n_fail++; $display("FAIL fill_ch1 t=%0d got %h exp %h", t, wsel(out_window, 1, t), 16'h100 + 16'(t)); end
        end
        send(4);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stride_k4 got %b exp 0", out_valid); end
        send(5);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stride_k5_valid got %b exp 1", out_valid); end
        n_cmp++; if (out_win_idx !== 16'd1) begin n_fail++; $display("FAIL stride_k5_idx got %0d exp 1", out_win_idx); end
        for (int t = 0; t < WS; t++) begin
            n_cmp++; if (wsel(out_window, 0, t) !== 16'(t + 2)) begin n_fail++; $display("FAIL stride_k5_ch0 t=%0d got %h exp %h", t, wsel(out_window, 0, t), 16'(t + 2)); end
            n_cmp++; if (wsel(out_window, 1, t) !== 16'h102 + 16'(t)) begin n_fail++; $display("FAIL stride_k5_ch1 t=%0d got %h exp %h", t, wsel(out_window, 1, t), 16'h102 + 16'(t)); end
        end
        send(6);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stride_k6 got %b exp 0", out_valid); end
        send(7);
        n_cmp++; if (out_win_idx !== 16'd2) begin n_fail++; $display("FAIL stride_k7_idx got %0d exp 2", out_win_idx); end
        for (int t = 0; t < WS; t++) begin
            n_cmp++; if (wsel(out_window, 0, t) !== 16'(t + 4)) begin n_fail++; $display("FAIL stride_k7_ch0 t=%0d got %h exp %h", t, wsel(out_window, 0, t), 16'(t + 4)); end
        end
    endtask

`ifndef EEG_WINDOW_DROP_MODE_EN
    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 6; k++) send(k);
        out_ready = 1'b0;
        send(6);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = smp(7);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready cyc=%0d got %b exp 0", i, in_ready); end
            n_cmp++; if (out_valid !== 1'b1 || out_win_idx !== 16'd1) begin n_fail++; $display("FAIL bp_hold_idx cyc=%0d got v=%b idx=%0d exp v=1 idx=1", i, out_valid, out_win_idx); end
            n_cmp++; if (wsel(out_window, 0, 0) !== 16'd2 || wsel(out_window, 0, 3) !== 16'd5) begin n_fail++; $display("FAIL bp_hold_win cyc=%0d got %h/%h exp 0002/0005", i, wsel(out_window, 0, 0), wsel(out_window, 0, 3)); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_win_idx !== 16'd2) begin n_fail++; $display("FAIL bp_release_idx got v=%b idx=%0d exp v=1 idx=2", out_valid, out_win_idx); end
        for (int t = 0; t < WS; t++) begin
            n_cmp++; if (wsel(out_window, 0, t) !== 16'(t + 4)) begin n_fail++; $display("FAIL bp_release_ch0 t=%0d got %h exp %h", t, wsel(out_window, 0, t), 16'(t + 4)); end
        end
    endtask
`else
    task automatic test_drop();
        do_reset();
        for (int k = 0; k < 6; k++) send(k);
        out_ready = 1'b0;
        send(6);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = smp(7);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drop_in_ready got %b exp 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt got %0d exp 1", drop_cnt); end
        n_cmp++; if (out_win_idx !== 16'd1 || wsel(out_window, 0, 3) !== 16'd5) begin n_fail++; $display("FAIL drop_hold got idx=%0d t3=%h exp idx=1 t3=0005", out_win_idx, wsel(out_window, 0, 3)); end
        @(negedge clk);
        out_ready = 1'b1;
        send(8);
        send(9);
        n_cmp++; if (out_valid !== 1'b1 || out_win_idx !== 16'd3) begin n_fail++; $display("FAIL drop_next_idx got v=%b idx=%0d exp v=1 idx=3", out_valid, out_win_idx); end
        for (int t = 0; t < WS; t++) begin
            n_cmp++; if (wsel(out_window, 0, t) !== 16'(t + 6)) begin n_fail++; $display("FAIL drop_next_ch0 t=%0d got %h exp %h", t, wsel(out_window, 0, t), 16'(t + 6)); end
        end
    endtask
`endif

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 6; k++) send(k);
        out_ready = 1'b0;
        @(negedge clk);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_sample = smp(6);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_win_idx !== 16'd1 || wsel(out_window, 0, 3) !== 16'd5) begin
            n_fail++; $display("FAIL flush_pending got v=%b idx=%0d t3=%h exp v=1 idx=1 t3=0005", out_valid, out_win_idx, wsel(out_window, 0, 3));
        end
        out_ready = 1'b1;
        for (int k = 7; k < 10; k++) begin
            send(k);
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_refill k=%0d got %b exp 0", k, out_valid); end
        end
        send(10);
        n_cmp++; if (out_valid !== 1'b1 || out_win_idx !== 16'd2) begin n_fail++; $display("FAIL flush_next_idx got v=%b idx=%0d exp v=1 idx=2", out_valid, out_win_idx); end
        for (int t = 0; t < WS; t++) begin
            n_cmp++; if (wsel(out_window, 0, t) !== 16'(t + 7)) begin n_fail++; $display("FAIL flush_next_ch0 t=%0d got %h exp %h", t, wsel(out_window, 0, t), 16'(t + 7)); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid1  = 1'b1;
            in_sample1 = smp(k);
            @(posedge clk);
            #1;
            if (k >= 3) begin
                n_cmp++; if (out_valid1 !== 1'b1 || out_win_idx1 !== 16'(k - 3)) begin n_fail++; $display("FAIL b2b_idx k=%0d got v=%b idx=%0d exp v=1 idx=%0d", k, out_valid1, out_win_idx1, k - 3); end
                n_cmp++; if (wsel(out_window1, 0, 0) !== 16'(k - 3) || wsel(out_window1, 0, 3) !== 16'(k)) begin
                    n_fail++; $display("FAIL b2b_win k=%0d got %h/%h exp %h/%h", k, wsel(out_window1, 0, 0), wsel(out_window1, 0, 3), 16'(k - 3), 16'(k));
                end
            end else begin
                n_cmp++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL b2b_early k=%0d got %b exp 0", k, out_valid1); end
            end
        end
        // Reset while the stream keeps running.
        @(negedge clk);
        rst        = 1'b1;
        in_sample1 = smp(10);
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid1 !== 1'b0 || out_win_idx1 !== '0 || out_window1 !== '0 || drop_cnt1 !== '0) begin
            n_fail++; $display("FAIL b2b_rst got v=%b idx=%0d win=%h drop=%0d exp all 0", out_valid1, out_win_idx1, out_window1, drop_cnt1);
        end
        @(negedge clk);
        rst       = 1'b0;
        in_valid1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_and_stride();
`ifndef EEG_WINDOW_DROP_MODE_EN
        test_backpressure();
`else
        test_drop();
`endif
        test_flush();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
